// File: rtl/exu_oitf_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : exu_oitf_if                                                     |
// | Purpose  : Dispatch, retire, hazard-check and status bundle for the OITF.  |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
interface exu_oitf_if #(
    parameter int OITF_DEPTH  = 4,
    parameter int RFIDX_WIDTH = 5,
    parameter int PC_SIZE     = 32
);
    localparam int PTR_W = $clog2(OITF_DEPTH);

    // Dispatch (allocation) side
    logic                   dis_ena;
    logic                   dis_ready;
    logic                   dis_rdwen;
    logic [RFIDX_WIDTH-1:0] dis_rdidx;
    logic [PC_SIZE-1:0]     dis_pc;
    logic [PTR_W-1:0]       dis_ptr;

    // Long-pipe write-back (retire) side
    logic                   ret_ena;
    logic [PTR_W-1:0]       ret_ptr;
    logic                   ret_rdwen;
    logic [RFIDX_WIDTH-1:0] ret_rdidx;
    logic [PC_SIZE-1:0]     ret_pc;

    // Hazard check of the instruction sitting in dispatch
    logic                   chk_rs1en;
    logic                   chk_rs2en;
    logic                   chk_rdwen;
    logic [RFIDX_WIDTH-1:0] chk_rs1idx;
    logic [RFIDX_WIDTH-1:0] chk_rs2idx;
    logic [RFIDX_WIDTH-1:0] chk_rdidx;
    logic                   oitf_rs1_match;
    logic                   oitf_rs2_match;
    logic                   oitf_rd_match;

    // Occupancy status
    logic                   oitf_empty;
    logic                   oitf_full;
    logic [PTR_W:0]         oitf_count;

    modport master (
        output dis_ena, dis_rdwen, dis_rdidx, dis_pc,
        output ret_ena,
        output chk_rs1en, chk_rs2en, chk_rdwen, chk_rs1idx, chk_rs2idx, chk_rdidx,
        input  dis_ready, dis_ptr,
        input  ret_ptr, ret_rdwen, ret_rdidx, ret_pc,
        input  oitf_rs1_match, oitf_rs2_match, oitf_rd_match,
        input  oitf_empty, oitf_full, oitf_count
    );

    modport slave (
        input  dis_ena, dis_rdwen, dis_rdidx, dis_pc,
        input  ret_ena,
        input  chk_rs1en, chk_rs2en, chk_rdwen, chk_rs1idx, chk_rs2idx, chk_rdidx,
        output dis_ready, dis_ptr,
        output ret_ptr, ret_rdwen, ret_rdidx, ret_pc,
        output oitf_rs1_match, oitf_rs2_match, oitf_rd_match,
        output oitf_empty, oitf_full, oitf_count
    );
endinterface : exu_oitf_if
`default_nettype wire

// File: rtl/exu_oitf.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : exu_oitf                                                        |
// | Purpose  : Outstanding Instruction Track FIFO: in-order long-pipe tracking |
// |            with RAW/WAW hazard detection against outstanding destinations. |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module exu_oitf #(
    parameter int OITF_DEPTH  = 4,
    parameter int RFIDX_WIDTH = 5,
    parameter int PC_SIZE     = 32
) (
    input  logic       clk,
    input  logic       rst,
    exu_oitf_if.slave  oitf
);
    localparam int             PTR_W   = $clog2(OITF_DEPTH);
    localparam logic [PTR_W:0] C_PTR_ONE = {{PTR_W{1'b0}}, 1'b1};

    // Pointers carry one extra MSB as the wrap flag to tell full from empty.
    logic [PTR_W:0]         r_wptr;
    logic [PTR_W:0]         r_rptr;
    logic [OITF_DEPTH-1:0]  r_vld;
    logic [OITF_DEPTH-1:0]  r_rdwen;
    logic [RFIDX_WIDTH-1:0] r_rdidx [OITF_DEPTH];
    logic [PC_SIZE-1:0]     r_pc    [OITF_DEPTH];

    logic [PTR_W-1:0]       w_widx;
    logic [PTR_W-1:0]       w_ridx;
    logic                   w_empty;
    logic                   w_full;
    logic                   w_alloc;
    logic                   w_ret;

    assign w_widx  = r_wptr[PTR_W-1:0];
    assign w_ridx  = r_rptr[PTR_W-1:0];
    assign w_empty = (r_wptr == r_rptr);
    assign w_full  = (w_widx == w_ridx) && (r_wptr[PTR_W] != r_rptr[PTR_W]);

    // Alloc and retire never touch the same slot: that needs full or empty,
    // and each case disables one side.
    assign w_alloc = oitf.dis_ena & ~w_full;
    assign w_ret   = oitf.ret_ena & ~w_empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_vld   <= '0;
            r_rdwen <= '0;
            for (int i = 0; i < OITF_DEPTH; i++) begin
                r_rdidx[i] <= '0;
                r_pc[i]    <= '0;
            end
        end else begin
            if (w_alloc) begin
                r_vld[w_widx]   <= 1'b1;
                r_rdwen[w_widx] <= oitf.dis_rdwen;
                r_rdidx[w_widx] <= oitf.dis_rdidx;
                r_pc[w_widx]    <= oitf.dis_pc;
                r_wptr          <= r_wptr + C_PTR_ONE;
            end
            if (w_ret) begin
                r_vld[w_ridx] <= 1'b0;
                r_rptr        <= r_rptr + C_PTR_ONE;
            end
        end
    end

    // Per-entry hazard hits; only valid entries that write rd participate.
    logic [OITF_DEPTH-1:0] w_rs1_hit;
    logic [OITF_DEPTH-1:0] w_rs2_hit;
    logic [OITF_DEPTH-1:0] w_rd_hit;

    for (genvar i = 0; i < OITF_DEPTH; i++) begin : g_entry
        logic w_live;
        assign w_live       = r_vld[i] & r_rdwen[i];
        assign w_rs1_hit[i] = w_live & (r_rdidx[i] == oitf.chk_rs1idx);
        assign w_rs2_hit[i] = w_live & (r_rdidx[i] == oitf.chk_rs2idx);
        assign w_rd_hit[i]  = w_live & (r_rdidx[i] == oitf.chk_rdidx);
    end

    // x0 is hard-wired zero, so a zero check index can never carry a hazard.
    assign oitf.oitf_rs1_match = oitf.chk_rs1en & (|oitf.chk_rs1idx) & (|w_rs1_hit);
    assign oitf.oitf_rs2_match = oitf.chk_rs2en & (|oitf.chk_rs2idx) & (|w_rs2_hit);
    assign oitf.oitf_rd_match  = oitf.chk_rdwen & (|oitf.chk_rdidx)  & (|w_rd_hit);

    assign oitf.dis_ready  = ~w_full;
    assign oitf.dis_ptr    = w_widx;
    assign oitf.ret_ptr    = w_ridx;
    assign oitf.ret_rdwen  = ~w_empty & r_rdwen[w_ridx];
    assign oitf.ret_rdidx  = w_empty ? '0 : r_rdidx[w_ridx];
    assign oitf.ret_pc     = w_empty ? '0 : r_pc[w_ridx];
    assign oitf.oitf_empty = w_empty;
    assign oitf.oitf_full  = w_full;
    assign oitf.oitf_count = r_wptr - r_rptr;

endmodule : exu_oitf
`default_nettype wire

// File: tb/tb_exu_oitf.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_exu_oitf                                                     |
// | Purpose  : Directed self-checking bench for exu_oitf.                      |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module tb_exu_oitf;
    localparam int OITF_DEPTH  = 4;
    localparam int RFIDX_WIDTH = 5;
    localparam int PC_SIZE     = 32;

    logic clk;
    logic rst;
    int   passed;
    int   total;

    exu_oitf_if #(.OITF_DEPTH(OITF_DEPTH), .RFIDX_WIDTH(RFIDX_WIDTH), .PC_SIZE(PC_SIZE)) bus ();

    exu_oitf #(.OITF_DEPTH(OITF_DEPTH), .RFIDX_WIDTH(RFIDX_WIDTH), .PC_SIZE(PC_SIZE)) dut (
        .clk  (clk),
        .rst  (rst),
        .oitf (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    // Inputs change 1 ns after the rising edge; outputs are sampled there too.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.dis_ena    = 1'b0;
        bus.dis_rdwen  = 1'b0;
        bus.dis_rdidx  = '0;
        bus.dis_pc     = '0;
        bus.ret_ena    = 1'b0;
        bus.chk_rs1en  = 1'b0;
        bus.chk_rs2en  = 1'b0;
        bus.chk_rdwen  = 1'b0;
        bus.chk_rs1idx = '0;
        bus.chk_rs2idx = '0;
        bus.chk_rdidx  = '0;
    endtask

    task automatic alloc(input int rd, input logic wen, input logic [31:0] pc);
        bus.dis_ena = 1'b1; bus.dis_rdwen = wen; bus.dis_rdidx = 5'(rd); bus.dis_pc = pc;
        tick();
        bus.dis_ena = 1'b0;
    endtask

    task automatic retire();
        bus.ret_ena = 1'b1;
        tick();
        bus.ret_ena = 1'b0;
    endtask

    task automatic test_reset();
        idle();
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        bus.chk_rs1en = 1'b1; bus.chk_rs1idx = 5'd1;
        total++; if (bus.dis_ready !== 1'b1) $display("FAIL rst_ready act=%0b exp=1", bus.dis_ready); else passed++;
        total++; if (bus.oitf_empty !== 1'b1) $display("FAIL rst_empty act=%0b exp=1", bus.oitf_empty); else passed++;
        total++; if (bus.oitf_full !== 1'b0) $display("FAIL rst_full act=%0b exp=0", bus.oitf_full); else passed++;
        total++; if (bus.oitf_count !== 3'd0) $display("FAIL rst_count act=%0d exp=0", bus.oitf_count); else passed++;
        total++; if (bus.dis_ptr !== 2'd0 || bus.ret_ptr !== 2'd0) $display("FAIL rst_ptrs act=%0d/%0d exp=0/0", bus.dis_ptr, bus.ret_ptr); else passed++;
        total++; if (bus.ret_rdwen !== 1'b0 || bus.ret_rdidx !== 5'd0 || bus.ret_pc !== 32'd0) $display("FAIL rst_ret act=%0b/%0d/%h exp=0/0/0", bus.ret_rdwen, bus.ret_rdidx, bus.ret_pc); else passed++;
        total++; if (bus.oitf_rs1_match !== 1'b0) $display("FAIL rst_match act=%0b exp=0", bus.oitf_rs1_match); else passed++;
        idle();
    endtask

    task automatic test_fill();
        for (int i = 1; i <= 4; i++) begin
            total++; if (bus.dis_ptr !== 2'(i - 1)) $display("FAIL fill_ptr%0d act=%0d exp=%0d", i, bus.dis_ptr, i - 1); else passed++;
            alloc(i, 1'b1, 32'h1000 + 32'(4 * i));
            total++; if (bus.oitf_count !== 3'(i)) $display("FAIL fill_count%0d act=%0d exp=%0d", i, bus.oitf_count, i); else passed++;
        end
        total++; if (bus.oitf_full !== 1'b1 || bus.dis_ready !== 1'b0) $display("FAIL fill_full act=%0b/%0b exp=1/0", bus.oitf_full, bus.dis_ready); else passed++;
        total++; if (bus.oitf_empty !== 1'b0) $display("FAIL fill_empty act=%0b exp=0", bus.oitf_empty); else passed++;
        alloc(9, 1'b1, 32'hDEAD0000);
        total++; if (bus.oitf_count !== 3'd4) $display("FAIL over_count act=%0d exp=4", bus.oitf_count); else passed++;
        total++; if (bus.dis_ptr !== 2'd0) $display("FAIL over_ptr act=%0d exp=0", bus.dis_ptr); else passed++;
        total++; if (bus.ret_rdidx !== 5'd1) $display("FAIL over_oldest act=%0d exp=1", bus.ret_rdidx); else passed++;
    endtask

    task automatic test_drain();
        for (int i = 1; i <= 4; i++) begin
            total++; if (bus.ret_rdidx !== 5'(i) || bus.ret_rdwen !== 1'b1) $display("FAIL drain_rd%0d act=%0d/%0b exp=%0d/1", i, bus.ret_rdidx, bus.ret_rdwen, i); else passed++;
            total++; if (bus.ret_pc !== 32'h1000 + 32'(4 * i)) $display("FAIL drain_pc%0d act=%h exp=%h", i, bus.ret_pc, 32'h1000 + 32'(4 * i)); else passed++;
            total++; if (bus.ret_ptr !== 2'(i - 1)) $display("FAIL drain_ptr%0d act=%0d exp=%0d", i, bus.ret_ptr, i - 1); else passed++;
            retire();
        end
        total++; if (bus.oitf_empty !== 1'b1 || bus.oitf_count !== 3'd0) $display("FAIL drain_empty act=%0b/%0d exp=1/0", bus.oitf_empty, bus.oitf_count); else passed++;
        total++; if (bus.ret_rdidx !== 5'd0 || bus.ret_pc !== 32'd0) $display("FAIL drain_retzero act=%0d/%h exp=0/0", bus.ret_rdidx, bus.ret_pc); else passed++;
        retire();
        total++; if (bus.oitf_empty !== 1'b1 || bus.oitf_count !== 3'd0 || bus.oitf_full !== 1'b0) $display("FAIL under_state act=%0b/%0d/%0b exp=1/0/0", bus.oitf_empty, bus.oitf_count, bus.oitf_full); else passed++;
        total++; if (bus.ret_ptr !== 2'd0) $display("FAIL under_ptr act=%0d exp=0", bus.ret_ptr); else passed++;
    endtask

    task automatic test_hazard();
        bus.chk_rs1en = 1'b1; bus.chk_rs1idx = 5'd5;
        bus.dis_ena = 1'b1; bus.dis_rdwen = 1'b1; bus.dis_rdidx = 5'd5; bus.dis_pc = 32'h3000;
        #1;
        total++; if (bus.oitf_rs1_match !== 1'b0) $display("FAIL haz_alloc_same_cycle act=%0b exp=0", bus.oitf_rs1_match); else passed++;
        tick();
        bus.dis_ena = 1'b0;
        alloc(0, 1'b1, 32'h3004);
        alloc(7, 1'b0, 32'h3008);
        #1;
        total++; if (bus.oitf_rs1_match !== 1'b1) $display("FAIL haz_rs1 act=%0b exp=1", bus.oitf_rs1_match); else passed++;
        bus.chk_rs1en = 1'b0; #1;
        total++; if (bus.oitf_rs1_match !== 1'b0) $display("FAIL haz_rs1_off act=%0b exp=0", bus.oitf_rs1_match); else passed++;
        bus.chk_rs2en = 1'b1; bus.chk_rs2idx = 5'd5; #1;
        total++; if (bus.oitf_rs2_match !== 1'b1) $display("FAIL haz_rs2 act=%0b exp=1", bus.oitf_rs2_match); else passed++;
        bus.chk_rs2idx = 5'd6; #1;
        total++; if (bus.oitf_rs2_match !== 1'b0) $display("FAIL haz_rs2_miss act=%0b exp=0", bus.oitf_rs2_match); else passed++;
        bus.chk_rdwen = 1'b1; bus.chk_rdidx = 5'd5; #1;
        total++; if (bus.oitf_rd_match !== 1'b1) $display("FAIL haz_rd act=%0b exp=1", bus.oitf_rd_match); else passed++;
        bus.chk_rdwen = 1'b0; #1;
        total++; if (bus.oitf_rd_match !== 1'b0) $display("FAIL haz_rd_off act=%0b exp=0", bus.oitf_rd_match); else passed++;
        bus.chk_rdwen = 1'b1; bus.chk_rdidx = 5'd0; bus.chk_rs1en = 1'b1; bus.chk_rs1idx = 5'd0; #1;
        total++; if (bus.oitf_rd_match !== 1'b0 || bus.oitf_rs1_match !== 1'b0) $display("FAIL haz_x0 act=%0b/%0b exp=0/0", bus.oitf_rd_match, bus.oitf_rs1_match); else passed++;
        bus.chk_rs1idx = 5'd7; #1;
        total++; if (bus.oitf_rs1_match !== 1'b0) $display("FAIL haz_nowen act=%0b exp=0", bus.oitf_rs1_match); else passed++;
        bus.chk_rs1idx = 5'd5; bus.ret_ena = 1'b1; #1;
        total++; if (bus.oitf_rs1_match !== 1'b1) $display("FAIL haz_retiring act=%0b exp=1", bus.oitf_rs1_match); else passed++;
        tick();
        bus.ret_ena = 1'b0;
        total++; if (bus.oitf_rs1_match !== 1'b0) $display("FAIL haz_retired act=%0b exp=0", bus.oitf_rs1_match); else passed++;
        retire();
        retire();
        total++; if (bus.oitf_empty !== 1'b1) $display("FAIL haz_end_empty act=%0b exp=1", bus.oitf_empty); else passed++;
        idle();
    endtask

    task automatic test_simultaneous();
        for (int i = 10; i <= 13; i++) alloc(i, 1'b1, 32'h4000 + 32'(i));
        total++; if (bus.oitf_full !== 1'b1) $display("FAIL sim_full act=%0b exp=1", bus.oitf_full); else passed++;
        bus.dis_ena = 1'b1; bus.dis_rdwen = 1'b1; bus.dis_rdidx = 5'd20; bus.dis_pc = 32'h4020;
        bus.ret_ena = 1'b1;
        tick();
        idle();
        total++; if (bus.oitf_count !== 3'd3 || bus.oitf_full !== 1'b0) $display("FAIL sim_full_both act=%0d/%0b exp=3/0", bus.oitf_count, bus.oitf_full); else passed++;
        total++; if (bus.ret_rdidx !== 5'd11) $display("FAIL sim_full_oldest act=%0d exp=11", bus.ret_rdidx); else passed++;
        retire(); retire();
        total++; if (bus.ret_rdidx !== 5'd13 || bus.oitf_count !== 3'd1) $display("FAIL sim_full_last act=%0d/%0d exp=13/1", bus.ret_rdidx, bus.oitf_count); else passed++;
        retire();
        bus.dis_ena = 1'b1; bus.dis_rdwen = 1'b1; bus.dis_rdidx = 5'd21; bus.dis_pc = 32'h4021;
        bus.ret_ena = 1'b1;
        tick();
        idle();
        total++; if (bus.oitf_count !== 3'd1 || bus.oitf_empty !== 1'b0) $display("FAIL sim_empty_both act=%0d/%0b exp=1/0", bus.oitf_count, bus.oitf_empty); else passed++;
        total++; if (bus.ret_rdidx !== 5'd21 || bus.ret_pc !== 32'h4021) $display("FAIL sim_empty_entry act=%0d/%h exp=21/4021", bus.ret_rdidx, bus.ret_pc); else passed++;
        retire();
    endtask

    task automatic test_wrap();
        int errs_ptr;
        int errs_flag;
        int errs_pc;
        errs_ptr = 0; errs_flag = 0; errs_pc = 0;
        for (int i = 0; i < 10; i++) begin
            if (bus.dis_ptr !== 2'(i % 4)) errs_ptr++;
            alloc(i + 1, 1'b1, 32'h2000 + 32'(4 * i));
            if (bus.oitf_empty !== 1'b0 || bus.oitf_full !== 1'b0 || bus.oitf_count !== 3'd1) errs_flag++;
            if (bus.ret_pc !== 32'h2000 + 32'(4 * i)) errs_pc++;
            retire();
            if (bus.oitf_empty !== 1'b1 || bus.oitf_full !== 1'b0) errs_flag++;
        end
        total++; if (errs_ptr != 0) $display("FAIL wrap_disptr act=%0d_bad exp=0_bad", errs_ptr); else passed++;
        total++; if (errs_flag != 0) $display("FAIL wrap_flags act=%0d_bad exp=0_bad", errs_flag); else passed++;
        total++; if (errs_pc != 0) $display("FAIL wrap_pc act=%0d_bad exp=0_bad", errs_pc); else passed++;
        total++; if (bus.dis_ptr !== 2'd2 || bus.ret_ptr !== 2'd2) $display("FAIL wrap_final_ptr act=%0d/%0d exp=2/2", bus.dis_ptr, bus.ret_ptr); else passed++;
    endtask

    task automatic test_reset_mid();
        alloc(3, 1'b1, 32'h5000);
        alloc(4, 1'b1, 32'h5004);
        alloc(5, 1'b1, 32'h5008);
        bus.chk_rs1en = 1'b1; bus.chk_rs1idx = 5'd3;
        bus.chk_rs2en = 1'b1; bus.chk_rs2idx = 5'd4;
        bus.chk_rdwen = 1'b1; bus.chk_rdidx  = 5'd5;
        #1;
        total++; if (bus.oitf_count !== 3'd3 || {bus.oitf_rs1_match, bus.oitf_rs2_match, bus.oitf_rd_match} !== 3'b111) $display("FAIL mid_pre act=%0d/%b exp=3/111", bus.oitf_count, {bus.oitf_rs1_match, bus.oitf_rs2_match, bus.oitf_rd_match}); else passed++;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        total++; if (bus.oitf_count !== 3'd0 || bus.oitf_empty !== 1'b1 || bus.dis_ready !== 1'b1) $display("FAIL mid_state act=%0d/%0b/%0b exp=0/1/1", bus.oitf_count, bus.oitf_empty, bus.dis_ready); else passed++;
        total++; if ({bus.oitf_rs1_match, bus.oitf_rs2_match, bus.oitf_rd_match} !== 3'b000) $display("FAIL mid_match act=%b exp=000", {bus.oitf_rs1_match, bus.oitf_rs2_match, bus.oitf_rd_match}); else passed++;
        total++; if (bus.dis_ptr !== 2'd0 || bus.ret_ptr !== 2'd0 || bus.ret_rdidx !== 5'd0) $display("FAIL mid_ptrs act=%0d/%0d/%0d exp=0/0/0", bus.dis_ptr, bus.ret_ptr, bus.ret_rdidx); else passed++;
        idle();
    endtask

    initial begin
        passed = 0;
        total  = 0;
        rst    = 1'b1;
        idle();
        test_reset();
        test_fill();
        test_drain();
        test_hazard();
        test_simultaneous();
        test_wrap();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule : tb_exu_oitf
`default_nettype wire
